// File: rtl/fft_pkg.sv
// Shared FFT constants, twiddle-fetch FSM states and FIFO entry layout.
package fft_pkg;
  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 9;
  localparam int NUM_STAGES = 10;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } tf_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] j;
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
  } tw_entry_t;
endpackage

// File: rtl/twiddle_fetch_if.sv
// Control, ROM and twiddle-stream signals of the twiddle fetcher.
interface twiddle_fetch_if;
  import fft_pkg::*;

  logic              i_start;
  logic [3:0]        i_stage;
  logic              o_busy;
  logic              o_done;
  logic              o_rom_rd_en;
  logic [ADDR_W-1:0] o_rom_rd_addr;
  logic [DATA_W-1:0] i_rom_re_data;
  logic [DATA_W-1:0] i_rom_im_data;
  logic              o_tw_valid;
  logic              i_tw_ready;
  logic [DATA_W-1:0] o_tw_re;
  logic [DATA_W-1:0] o_tw_im;
  logic [ADDR_W-1:0] o_bfly_idx;

  modport master (
    input  i_start, i_stage,
    input  i_rom_re_data, i_rom_im_data,
    input  i_tw_ready,
    output o_busy, o_done,
    output o_rom_rd_en, o_rom_rd_addr,
    output o_tw_valid, o_tw_re, o_tw_im,
    output o_bfly_idx
  );

  modport slave (
    output i_start, i_stage,
    output i_rom_re_data, i_rom_im_data,
    output i_tw_ready,
    input  o_busy, o_done,
    input  o_rom_rd_en, o_rom_rd_addr,
    input  o_tw_valid, o_tw_re, o_tw_im,
    input  o_bfly_idx
  );
endinterface

// File: rtl/tw_fifo2.sv
// Two-entry FIFO of tagged twiddle pairs with occupancy count.
module tw_fifo2
  import fft_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      push,
  input  tw_entry_t din,
  input  logic      pop,
  output tw_entry_t dout,
  output logic [1:0] count
);

  tw_entry_t mem [2];
  logic      wr_ptr;
  logic      rd_ptr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/twiddle_fetch.sv
// Streams one FFT stage's twiddles from re/im ROMs through a
// 2-deep skid FIFO with valid/ready flow control.
module twiddle_fetch
  import fft_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  twiddle_fetch_if.master bus
);

  tf_state_e         state;
  tf_state_e         state_nxt;
  logic [3:0]        stage_q;
  logic [ADDR_W-1:0] rd_j;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_j;
  logic [1:0]        count;
  logic [2:0]        occ;
  logic              tw_valid;
  logic              pop;
  logic              issue;
  logic              accept;
  logic [ADDR_W-1:0] mask;
  logic [3:0]        sh;
  logic [ADDR_W-1:0] addr;
  tw_entry_t         wr_entry;
  tw_entry_t         head;

  assign tw_valid = (count != 2'd0);
  assign pop      = tw_valid & bus.i_tw_ready;
  // Slots already claimed once this cycle's pop is taken into account.
  assign occ = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.i_start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!i_rst && occ < 3'd2) begin
          issue = 1'b1;
          if (rd_j == '1) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (occ == 3'd0) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address = (j mod 2^s) << (9 - s): mask low s bits, then shift.
  assign mask = ~({ADDR_W{1'b1}} << stage_q);
  assign sh   = 4'(ADDR_W) - stage_q;
  assign addr = (rd_j & mask) << sh;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stage_q    <= 4'd0;
      rd_j       <= '0;
      inflight   <= 1'b0;
      inflight_j <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_j <= rd_j;
        rd_j       <= rd_j + 1'b1;
      end
      if (accept) begin
        rd_j    <= '0;
        stage_q <= (bus.i_stage > 4'(NUM_STAGES - 1))
                 ? 4'(NUM_STAGES - 1) : bus.i_stage;
      end
    end
  end

  assign wr_entry.j  = inflight_j;
  assign wr_entry.re = bus.i_rom_re_data;
  assign wr_entry.im = bus.i_rom_im_data;

  tw_fifo2 u_fifo (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .push  (inflight),
    .din   (wr_entry),
    .pop   (pop),
    .dout  (head),
    .count (count)
  );

  assign bus.o_busy        = (state != IDLE);
  assign bus.o_done        = (state == DONE);
  assign bus.o_rom_rd_en   = issue;
  assign bus.o_rom_rd_addr = issue ? addr : '0;
  assign bus.o_tw_valid    = tw_valid;
  assign bus.o_tw_re       = head.re;
  assign bus.o_tw_im       = head.im;
  assign bus.o_bfly_idx    = head.j;

endmodule

// File: tb/tb_twiddle_fetch.sv
// Directed bench for twiddle_fetch with behavioural cos/-sin ROMs.
module tb_twiddle_fetch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  twiddle_fetch_if bus ();

  twiddle_fetch dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  logic [15:0] rom_re [512];
  logic [15:0] rom_im [512];
  logic [15:0] got_re [512];
  logic [15:0] got_im [512];
  logic [15:0] ref_re [512];
  logic [15:0] ref_im [512];

  int errors = 0;
  int checks = 0;
  int first_valid;
  int done_cyc;

  // Registered ROMs: data one cycle after rd_en, zeros otherwise.
  always @(posedge clk) begin
    bus.i_rom_re_data <= bus.o_rom_rd_en ? rom_re[bus.o_rom_rd_addr] : 16'h0;
    bus.i_rom_im_data <= bus.o_rom_rd_en ? rom_im[bus.o_rom_rd_addr] : 16'h0;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_addr(input int s, input int j);
    int e;
    e = (s > 9) ? 9 : s;
    return (j % (1 << e)) * (1 << (9 - e));
  endfunction

  task automatic run_stage(input int s, input bit rnd, input int dup_at);
    int n;
    int rd_cnt;
    int exp_j;
    bit stalled;
    logic [24:0] held;
    logic [15:0] held_im;
    @(negedge clk);
    bus.i_start    = 1'b1;
    bus.i_stage    = 4'(s);
    bus.i_tw_ready = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_stage = 4'd0;
    n = 0; rd_cnt = 0; exp_j = 0; stalled = 0;
    held = '0; held_im = '0;
    first_valid = -1; done_cyc = -1;
    while (n < 2000 && done_cyc < 0) begin
      bus.i_start    = (n == dup_at);
      bus.i_tw_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (n == 0) chk("busy_start", 32'(bus.o_busy), 32'd1);
      if (bus.o_rom_rd_en) begin
        chk("rd_addr", 32'(bus.o_rom_rd_addr), 32'(exp_addr(s, rd_cnt)));
        rd_cnt++;
      end
      if (bus.o_tw_valid) begin
        if (first_valid < 0) first_valid = n;
        if (stalled) begin
          chk("stall_hold", 32'({bus.o_bfly_idx, bus.o_tw_re}), 32'(held));
          chk("stall_im", 32'(bus.o_tw_im), 32'(held_im));
        end
        if (bus.i_tw_ready) begin
          stalled = 0;
          chk("bfly_idx", 32'(bus.o_bfly_idx), 32'(exp_j));
          if (exp_j < 512) begin
            chk("tw_re", 32'(bus.o_tw_re), 32'(rom_re[exp_addr(s, exp_j)]));
            chk("tw_im", 32'(bus.o_tw_im), 32'(rom_im[exp_addr(s, exp_j)]));
            got_re[exp_j] = bus.o_tw_re;
            got_im[exp_j] = bus.o_tw_im;
          end
          exp_j++;
        end else begin
          stalled = 1;
          held    = {bus.o_bfly_idx, bus.o_tw_re};
          held_im = bus.o_tw_im;
        end
      end
      if (bus.o_done) begin
        done_cyc = n;
        chk("busy_at_done", 32'(bus.o_busy), 32'd1);
      end
      @(negedge clk);
      n++;
    end
    bus.i_start = 1'b0;
    chk("transfers", 32'(exp_j), 32'd512);
    chk("reads", 32'(rd_cnt), 32'd512);
    chk("done_seen", 32'(done_cyc >= 0), 32'd1);
    #1;
    chk("idle_after", 32'(bus.o_busy), 32'd0);
  endtask

  initial begin
    real  ang;
    int   bad;
    int   n;
    bit   found;

    for (int k = 0; k < 512; k++) begin
      ang       = 3.14159265358979 * k / 512.0;
      rom_re[k] = 16'($rtoi($floor(32767.0 * $cos(ang) + 0.5)));
      rom_im[k] = 16'($rtoi($floor(-32767.0 * $sin(ang) + 0.5)));
    end

    bus.i_start    = 1'b0;
    bus.i_stage    = 4'd0;
    bus.i_tw_ready = 1'b0;
    rst            = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_done", 32'(bus.o_done), 32'd0);
    chk("rst_valid", 32'(bus.o_tw_valid), 32'd0);
    chk("rst_rd_en", 32'(bus.o_rom_rd_en), 32'd0);
    chk("rst_rd_addr", 32'(bus.o_rom_rd_addr), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("idle_rd_en", 32'(bus.o_rom_rd_en), 32'd0);

    // Stage 9, always ready: addresses follow j, fixed latencies.
    run_stage(9, 1'b0, -1);
    chk("s9_first_valid", 32'(first_valid), 32'd2);
    chk("s9_done_cycle", 32'(done_cyc), 32'd514);

    // Stage 0: every twiddle is W^0.
    run_stage(0, 1'b0, -1);
    bad = 0;
    for (int k = 0; k < 512; k++)
      if (got_re[k] !== 16'h7FFF || got_im[k] !== 16'h0000) bad++;
    chk("s0_all_w0", 32'(bad), 32'd0);

    // Stage 3: j=5 reads ROM[(5 mod 8) << 6] = ROM[320].
    run_stage(3, 1'b0, -1);
    chk("s3_j5_re", 32'(got_re[5]), 32'(rom_re[320]));
    chk("s3_j5_im", 32'(got_im[5]), 32'(rom_im[320]));

    // Stage 7 with and without backpressure must match.
    run_stage(7, 1'b0, -1);
    for (int k = 0; k < 512; k++) begin
      ref_re[k] = got_re[k];
      ref_im[k] = got_im[k];
    end
    run_stage(7, 1'b1, -1);
    bad = 0;
    for (int k = 0; k < 512; k++)
      if (got_re[k] !== ref_re[k] || got_im[k] !== ref_im[k]) bad++;
    chk("s7_rand_same", 32'(bad), 32'd0);

    // Reset mid-stream with read 199 in flight.
    @(negedge clk);
    bus.i_start    = 1'b1;
    bus.i_stage    = 4'd9;
    bus.i_tw_ready = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    n = 0;
    found = 0;
    while (n < 1000 && !found) begin
      #1;
      if (bus.o_rom_rd_en && bus.o_rom_rd_addr == 9'd200) found = 1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    chk("rst_reach_200", 32'(found), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_rd_en", 32'(bus.o_rom_rd_en), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(bus.o_tw_valid), 32'd0);
    chk("rst_mid_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_mid_done", 32'(bus.o_done), 32'd0);
    chk("rst_mid_addr", 32'(bus.o_rom_rd_addr), 32'd0);
    @(negedge clk);
    #1;
    chk("rst_discard", 32'(bus.o_tw_valid), 32'd0);
    run_stage(9, 1'b0, -1);
    chk("after_rst_done", 32'(done_cyc), 32'd514);

    // Out-of-range stage clamps to 9; a start while busy is ignored.
    run_stage(12, 1'b0, 100);
    chk("s12_done_cycle", 32'(done_cyc), 32'd514);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/twiddle_fetch.md
TWIDDLE_FETCH -- requirements
Module: twiddle_fetch

Interface
REQ-001 Parameter DATA_W, 16, twiddle component width in Q1.15.
REQ-002 Parameter ADDR_W, 9, ROM address width, giving 512 butterflies per stage and 10 stages (0..9).
REQ-003 i_clk  in  1  sole clock; all logic SHALL be on posedge i_clk.
REQ-004 i_rst  in  1  reset, synchronous and active-high.
REQ-005 i_start  in  1  single-cycle request to stream one stage's twiddles.
REQ-006 i_stage  in  4  stage index, sampled when i_start is accepted.
REQ-007 o_busy  out  1  high from the accepted start until the o_done cycle, inclusive.
REQ-008 o_done  out  1  one-cycle pulse after the last twiddle is accepted.
REQ-009 o_rom_rd_en  out  1  read enable, shared by the real and imaginary ROMs.
REQ-010 o_rom_rd_addr  out  ADDR_W  read address, shared by both ROMs.
REQ-011 i_rom_re_data  in  DATA_W  real ROM data, valid the cycle after rd_en.
REQ-012 i_rom_im_data  in  DATA_W  imaginary ROM data, valid the cycle after rd_en.
REQ-013 o_tw_valid  out  1  twiddle output valid.
REQ-014 i_tw_ready  in  1  consumer ready; a transfer occurs when valid and ready are both high.
REQ-015 o_tw_re, o_tw_im  out  DATA_W  twiddle pair.
REQ-016 o_bfly_idx  out  ADDR_W  butterfly index j of the presented twiddle.

Function
REQ-017 FSM states SHALL be IDLE, RUN, DRAIN and DONE.
- IDLE->RUN on i_start.
- RUN->DRAIN after read j=511 is issued.
- DRAIN->DONE when the buffer is empty and no read is in flight.
- DONE->IDLE unconditionally after one cycle.
REQ-018 i_start SHALL be ignored outside IDLE.
REQ-019 An i_stage value above 9 SHALL be latched as 9.
REQ-020 For latched stage s and butterfly j (0..511), the address SHALL be (j mod 2^s) << (9-s); stage 0 gives all zeros and stage 9 gives j.
REQ-021 Read j SHALL be issued in strictly ascending order, one read per cycle at most; o_rom_rd_en SHALL be high only in RUN when issuing.
REQ-022 Returned ROM data SHALL be captured into a 2-entry FIFO exactly one cycle after the corresponding rd_en, tagged with its j.
- ROM data outside that cycle SHALL be ignored; the ROM drives zeros when not enabled.
REQ-023 A read SHALL be issued only when fifo_count + inflight - pop < 2, where pop = valid and ready this cycle; no entry is ever lost or overwritten.
REQ-024 With i_tw_ready held high, the block SHALL sustain one twiddle per cycle after a 2-cycle start latency: the first o_tw_valid appears 2 cycles after i_start.
REQ-025 o_tw_valid SHALL equal FIFO non-empty, and outputs SHALL hold stable while valid and not ready.
REQ-026 o_tw_re, o_tw_im and o_bfly_idx SHALL present the FIFO head entry and are don't-care when not valid.
REQ-027 Exactly 512 transfers SHALL occur per start; o_done SHALL rise the cycle after the 512th transfer.
REQ-028 A ready deassertion at any point, including while a read is in flight, SHALL only stall; no data is reordered or dropped.

Reset
REQ-029 On i_rst, the block SHALL enter IDLE and clear the FIFO, counters and in-flight flag; o_busy, o_done, o_tw_valid and o_rom_rd_en SHALL be 0 and o_rom_rd_addr SHALL be 0.
REQ-030 Reset mid-stream SHALL abort the stage; ROM data returning the cycle after reset SHALL be discarded.

Structure
REQ-031 A shared package (fft_pkg) SHALL hold DATA_W, ADDR_W, NUM_STAGES=10 and the FSM state enum.
REQ-032 One sub-module, tw_fifo2, SHALL implement the 2-entry FIFO of {j, re, im} with count output.
REQ-033 The address generator SHALL be a barrel mask and shift inline in twiddle_fetch, with no multiplier.

Verification
REQ-034 The bench SHALL cover the directed scenarios below, using two behavioural rom_512x16 instances loaded with known cos/-sin tables.
- Stage 9, ready=1 -> addresses 0..511 in order, 512 transfers in 513 cycles, o_done at cycle 514 after start.
- Stage 0 -> every rd_addr is 0 and all 512 outputs are (0x7FFF, 0x0000).
- Stage 3 -> rd_addr sequence 0,64,128,...,448,0,64,...; the output at j=5 is ROM[320].
- Random ready (50% duty), stage 7 -> the output sequence is identical to the ready=1 run, with no duplicates or gaps and stable data during stalls.
- i_rst asserted at j=200 with a read in flight -> next cycle o_tw_valid=0 and IDLE; a new start on stage 9 begins at j=0.
- i_stage=12 -> behaves as stage 9; i_start while busy -> ignored, still exactly 512 transfers.
